v_vram: RTL and testbench

Vector data memory that answers the vector core's VRAM read/write port. It holds DEPTH words of DATA_W bits and accepts one read and one bit-masked write per cycle. Reads return registered data one cycle later with a valid strobe. After every reset it zero-fills itself via a sequential clear state machine and reports busy until the fill is done. It sits beside the vector core in the top level, with its ports wired one-to-one to the core's vram_* ports.

---
 rtl/v_vram.sv | 126 ++++++++++++
 tb/tb_v_vram.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/v_vram.sv
// Vector data memory for the vector core's VRAM port: one read and one bit-masked
// write per cycle, registered read data, and a zero-fill sequence after every reset.
module v_vram #(
   parameter int DATA_W = 256,
   parameter int ADDR_W = 64,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vram_r_ena,
   input  logic [ADDR_W-1:0] vram_r_addr,
   output logic [DATA_W-1:0] vram_r_data,
   output logic              vram_r_valid,
   input  logic              vram_w_ena,
   input  logic [ADDR_W-1:0] vram_w_addr,
   input  logic [DATA_W-1:0] vram_w_data,
   input  logic [DATA_W-1:0] vram_w_mask,
   output logic              vram_busy
);

   localparam int OFF   = $clog2(DATA_W / 8);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [IDX_W-1:0]  clr_idx_r;
   logic [IDX_W-1:0]  clr_idx_nxt_s;
   logic [DATA_W-1:0] mem_r [DEPTH];

   logic [IDX_W-1:0]  r_idx_s;
   logic [IDX_W-1:0]  w_idx_s;
   logic [DATA_W-1:0] merged_s;
   logic [DATA_W-1:0] rd_word_s;
   logic              ready_s;
   logic              unused_addr_s;

   function automatic logic [DATA_W-1:0] merge_word(
      input logic [DATA_W-1:0] old_word,
      input logic [DATA_W-1:0] new_word,
      input logic [DATA_W-1:0] mask
   );
      return (old_word & ~mask) | (new_word & mask);
   endfunction

   // Offset bits and bits above the index are dropped: no misalignment error, addresses wrap.
   assign r_idx_s       = vram_r_addr[OFF+IDX_W-1:OFF];
   assign w_idx_s       = vram_w_addr[OFF+IDX_W-1:OFF];
   assign unused_addr_s = ^{vram_r_addr, vram_w_addr};
   assign ready_s       = (state_r == READY);
   assign vram_busy     = (state_r == CLEAR);

   // Merged write word and write-first read-data selection.
   always_comb begin
      merged_s  = merge_word(mem_r[w_idx_s], vram_w_data, vram_w_mask);
      rd_word_s = mem_r[r_idx_s];
      if (vram_w_ena && (w_idx_s == r_idx_s)) begin
         rd_word_s = merged_s;
      end else begin
         rd_word_s = mem_r[r_idx_s];
      end
   end

   // Next-state logic for the clear sequencer.
   always_comb begin
      state_nxt_s   = state_r;
      clr_idx_nxt_s = clr_idx_r;
      case (state_r)
         CLEAR: begin
            clr_idx_nxt_s = clr_idx_r + IDX_W'(1);
            if (clr_idx_r == LAST_IDX) begin
               state_nxt_s = READY;
            end else begin
               state_nxt_s = CLEAR;
            end
         end
         READY: begin
            state_nxt_s   = READY;
            clr_idx_nxt_s = clr_idx_r;
         end
         default: begin
            state_nxt_s   = CLEAR;
            clr_idx_nxt_s = '0;
         end
      endcase
   end

   // Clear sequencer state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= CLEAR;
         clr_idx_r <= '0;
      end else begin
         state_r   <= state_nxt_s;
         clr_idx_r <= clr_idx_nxt_s;
      end
   end

   // Storage array: clear write wins while busy, otherwise the masked request write.
   always_ff @(posedge clk) begin
      if (!ready_s) begin
         mem_r[clr_idx_r] <= '0;
      end else if (vram_w_ena) begin
         mem_r[w_idx_s] <= merged_s;
      end
   end

   // Registered read port; data holds when no read is issued.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vram_r_data  <= '0;
         vram_r_valid <= 1'b0;
      end else if (ready_s && vram_r_ena) begin
         vram_r_data  <= rd_word_s;
         vram_r_valid <= 1'b1;
      end else begin
         vram_r_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_v_vram.sv
// Directed self-checking bench for v_vram with hand-computed expected words.
module tb_v_vram;

   logic         clk;
   logic         rst;
   logic         vram_r_ena;
   logic [63:0]  vram_r_addr;
   logic [255:0] vram_r_data;
   logic         vram_r_valid;
   logic         vram_w_ena;
   logic [63:0]  vram_w_addr;
   logic [255:0] vram_w_data;
   logic [255:0] vram_w_mask;
   logic         vram_busy;

   int checks = 0;
   int errors = 0;

   logic [255:0] ones;
   logic [255:0] pat1;
   logic [255:0] pat2;
   logic [255:0] pat_a5;
   logic [255:0] low_ff;
   logic [255:0] low64;

   v_vram dut (
      .clk          (clk),
      .rst          (rst),
      .vram_r_ena   (vram_r_ena),
      .vram_r_addr  (vram_r_addr),
      .vram_r_data  (vram_r_data),
      .vram_r_valid (vram_r_valid),
      .vram_w_ena   (vram_w_ena),
      .vram_w_addr  (vram_w_addr),
      .vram_w_data  (vram_w_data),
      .vram_w_mask  (vram_w_mask),
      .vram_busy    (vram_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Release reset and count edges until busy falls; optionally inject requests at cycle 10.
   task automatic run_clear(input bit inject, input string tag);
      int  cnt;
      bit  vseen;
      cnt   = 0;
      vseen = 1'b0;
      rst   = 1'b1;
      while (vram_busy && cnt < 200) begin
         if (inject && cnt == 10) begin
            vram_w_ena  = 1'b1;
            vram_w_addr = 64'h0;
            vram_w_data = ones;
            vram_w_mask = ones;
            vram_r_ena  = 1'b1;
            vram_r_addr = 64'h0;
         end
         @(posedge clk);
         @(negedge clk);
         vram_w_ena = 1'b0;
         vram_r_ena = 1'b0;
         cnt++;
         if (vram_r_valid) vseen = 1'b1;
      end
      check({tag, "_busy_cycles"}, 256'(cnt), 256'd64);
      check({tag, "_valid_in_clear"}, 256'(vseen), 256'd0);
   endtask

   task automatic do_write(input logic [63:0] addr, input logic [255:0] data, input logic [255:0] mask);
      vram_w_ena  = 1'b1;
      vram_w_addr = addr;
      vram_w_data = data;
      vram_w_mask = mask;
      @(negedge clk);
      vram_w_ena  = 1'b0;
   endtask

   task automatic do_read(input logic [63:0] addr, input logic [255:0] exp, input string tag);
      vram_r_ena  = 1'b1;
      vram_r_addr = addr;
      @(negedge clk);
      vram_r_ena  = 1'b0;
      check({tag, "_valid"}, 256'(vram_r_valid), 256'd1);
      check({tag, "_data"}, vram_r_data, exp);
   endtask

   initial begin
      ones   = '1;
      pat1   = {64{4'h1}};
      pat2   = {64{4'h2}};
      pat_a5 = {32{8'hA5}};
      low_ff = 256'hFF;
      low64  = {192'd0, {64{1'b1}}};

      rst         = 1'b0;
      vram_r_ena  = 1'b0;
      vram_r_addr = 64'h0;
      vram_w_ena  = 1'b0;
      vram_w_addr = 64'h0;
      vram_w_data = '0;
      vram_w_mask = '0;

      repeat (3) @(negedge clk);
      check("rst_data", vram_r_data, 256'd0);
      check("rst_valid", 256'(vram_r_valid), 256'd0);
      check("rst_busy", 256'(vram_busy), 256'd1);

      // Startup clear with a dropped write/read at cycle 10.
      run_clear(1'b1, "clr1");
      do_read(64'h0,   256'd0, "rd_0x0");
      do_read(64'h20,  256'd0, "rd_0x20");
      do_read(64'h7E0, 256'd0, "rd_0x7e0");
      @(negedge clk);
      check("idle_valid_drop", 256'(vram_r_valid), 256'd0);
      check("idle_data_hold", vram_r_data, 256'd0);

      // Masked write.
      do_write(64'h40, ones, ones);
      do_write(64'h40, 256'd0, low_ff);
      do_read(64'h40, ~low_ff, "mask_rd");

      // Write-first collisions, full and partial mask.
      do_write(64'h60, pat1, ones);
      vram_r_ena  = 1'b1;
      vram_r_addr = 64'h60;
      do_write(64'h60, pat2, ones);
      vram_r_ena  = 1'b0;
      check("coll_valid", 256'(vram_r_valid), 256'd1);
      check("coll_data", vram_r_data, pat2);
      vram_r_ena  = 1'b1;
      vram_r_addr = 64'h60;
      do_write(64'h60, pat1, low64);
      vram_r_ena  = 1'b0;
      check("coll_part_data", vram_r_data, (pat2 & ~low64) | (pat1 & low64));

      // Simultaneous read and write to different words.
      vram_r_ena  = 1'b1;
      vram_r_addr = 64'h40;
      do_write(64'hA0, pat_a5, ones);
      vram_r_ena  = 1'b0;
      check("diff_rd_data", vram_r_data, ~low_ff);
      do_read(64'hA0, pat_a5, "diff_wr");

      // Wrap and misalignment: 0x825 maps to word 1.
      do_write(64'h825, pat_a5, ones);
      do_read(64'h20, pat_a5, "wrap_rd");

      // Back-to-back reads.
      vram_r_ena  = 1'b1;
      vram_r_addr = 64'h20;
      @(negedge clk);
      check("b2b0", vram_r_data, pat_a5);
      vram_r_addr = 64'h40;
      @(negedge clk);
      check("b2b1_valid", 256'(vram_r_valid), 256'd1);
      check("b2b1", vram_r_data, ~low_ff);
      vram_r_addr = 64'h0;
      @(negedge clk);
      check("b2b2_valid", 256'(vram_r_valid), 256'd1);
      check("b2b2", vram_r_data, 256'd0);

      // Reset on the same edge as a streamed read.
      vram_r_addr = 64'h20;
      @(posedge clk);
      rst = 1'b0;
      #1;
      vram_r_ena = 1'b0;
      check("mid_rst_valid", 256'(vram_r_valid), 256'd0);
      check("mid_rst_data", vram_r_data, 256'd0);
      check("mid_rst_busy", 256'(vram_busy), 256'd1);
      @(negedge clk);
      run_clear(1'b0, "clr2");
      do_read(64'h20, 256'd0, "post_rst_rd");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
